// File: rtl/dmem_ctrl.sv
// Data-memory controller: M-stage load/store to a handshaked word bus with stall, lane steering and timeout.
// Optional DMEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of forcing natural alignment.
module dmem_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [2:0]  funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        StallMem,
   output logic        MisalignM,
   output logic        BusErrM,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ready
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [7:0]  timeout_cnt;
   logic [2:0]  funct3_q;
   logic [1:0]  lane_q;

   logic        access;
   logic        misaligned;
   logic [1:0]  lane;
   logic [3:0]  strobe;
   logic [31:0] wdata;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_val;

   assign access = MemReadM | MemWriteM;

`ifdef DMEM_MISALIGN_TRAP_EN
   always_comb begin
      misaligned = 1'b0;
      case (funct3M[1:0])
         2'b01:   misaligned = ALUResultM[0];
         2'b10:   misaligned = |ALUResultM[1:0];
         default: misaligned = 1'b0;
      endcase
   end

   assign lane = ALUResultM[1:0];
`else
   assign misaligned = 1'b0;

   // Without trapping, stray low address bits are dropped to the access's natural alignment.
   always_comb begin
      lane = ALUResultM[1:0];
      case (funct3M[1:0])
         2'b01:   lane = {ALUResultM[1], 1'b0};
         2'b10:   lane = 2'b00;
         default: lane = ALUResultM[1:0];
      endcase
   end
`endif

   always_comb begin
      strobe = 4'h0;
      wdata  = WriteDataM;
      case (funct3M[1:0])
         2'b00: begin
            strobe = 4'b0001 << lane;
            wdata  = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            strobe = 4'b0011 << {lane[1], 1'b0};
            wdata  = {2{WriteDataM[15:0]}};
         end
         2'b10: begin
            strobe = 4'hF;
            wdata  = WriteDataM;
         end
         default: begin
            strobe = 4'h0;
            wdata  = WriteDataM;
         end
      endcase
   end

   assign rd_byte = bus_rdata[{lane_q, 3'b000} +: 8];
   assign rd_half = bus_rdata[{lane_q[1], 4'b0000} +: 16];

   always_comb begin
      load_val = 32'h0;
      case (funct3_q)
         3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
         3'b010:  load_val = bus_rdata;
         3'b100:  load_val = {24'h0, rd_byte};
         3'b101:  load_val = {16'h0, rd_half};
         default: load_val = 32'h0;
      endcase
   end

   assign StallMem = ((state == IDLE) && access && !misaligned) || (state == REQ);

   // Request fields are latched once on acceptance so they stay stable for the whole REQ phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         timeout_cnt <= 8'h0;
         funct3_q    <= 3'b000;
         lane_q      <= 2'b00;
         bus_req     <= 1'b0;
         bus_we      <= 1'b0;
         bus_addr    <= 32'h0;
         bus_wstrb   <= 4'h0;
         bus_wdata   <= 32'h0;
         ReadDataM   <= 32'h0;
         MisalignM   <= 1'b0;
         BusErrM     <= 1'b0;
      end else begin
         MisalignM <= 1'b0;
         BusErrM   <= 1'b0;
         case (state)
            IDLE: begin
               if (access && !misaligned) begin
                  state       <= REQ;
                  timeout_cnt <= 8'h0;
                  funct3_q    <= funct3M;
                  lane_q      <= lane;
                  bus_req     <= 1'b1;
                  bus_we      <= MemWriteM;
                  bus_addr    <= {ALUResultM[31:2], 2'b00};
                  bus_wstrb   <= MemWriteM ? strobe : 4'h0;
                  bus_wdata   <= MemWriteM ? wdata : 32'h0;
               end else if (access && misaligned) begin
                  MisalignM <= 1'b1;
                  if (!MemWriteM) begin
                     ReadDataM <= 32'h0;
                  end
               end
            end
            REQ: begin
               if (bus_ready) begin
                  ReadDataM <= load_val;
                  bus_req   <= 1'b0;
                  state     <= DONE;
               end else if (timeout_cnt == LAST_WAIT) begin
                  BusErrM   <= 1'b1;
                  ReadDataM <= 32'h0;
                  bus_req   <= 1'b0;
                  state     <= DONE;
               end else begin
                  timeout_cnt <= timeout_cnt + 8'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               bus_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: table-driven load/store vectors checked through a scoreboard queue,
// plus hand-written timeout, misalignment and mid-transaction reset sequences.
`timescale 1ns/1ps
module tb_dmem_ctrl;

   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          readyAt;
      logic [31:0] expAddr;
      logic [3:0]  expStrb;
      logic [31:0] expWdata;
      logic [31:0] expRead;
      int          expStall;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        MemReadM;
   logic        MemWriteM;
   logic [2:0]  funct3M;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [31:0] ReadDataM;
   logic        StallMem;
   logic        MisalignM;
   logic        BusErrM;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ready;

   logic        rd2;
   logic        wr2;
   logic        ready2;
   logic [31:0] ReadDataM2;
   logic        StallMem2;
   logic        MisalignM2;
   logic        BusErrM2;
   logic        bus_req2;
   logic        bus_we2;
   logic [31:0] bus_addr2;
   logic [3:0]  bus_wstrb2;
   logic [31:0] bus_wdata2;

   int   passCount = 0;
   int   checkCount = 0;
   vec_t expQ[$];

   dmem_ctrl dut (
      .clk(clk), .rst(rst),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .ReadDataM(ReadDataM), .StallMem(StallMem), .MisalignM(MisalignM), .BusErrM(BusErrM),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
   );

   // Second instance with a short timeout so bus-error handling is reachable quickly.
   dmem_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
      .clk(clk), .rst(rst),
      .MemReadM(rd2), .MemWriteM(wr2), .funct3M(funct3M),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .ReadDataM(ReadDataM2), .StallMem(StallMem2), .MisalignM(MisalignM2), .BusErrM(BusErrM2),
      .bus_req(bus_req2), .bus_we(bus_we2), .bus_addr(bus_addr2), .bus_wstrb(bus_wstrb2),
      .bus_wdata(bus_wdata2), .bus_rdata(bus_rdata), .bus_ready(ready2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic checkOutput(input logic done, input int stall, input logic [31:0] a0,
                              input logic [3:0] s0, input logic [31:0] d0, input logic we0,
                              input logic stable, input logic misSeen, input logic errSeen,
                              input logic [31:0] rdata);
      vec_t e;
      if (expQ.size() == 0) begin
         checkValue("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = expQ.pop_front();
      checkValue({e.name, "_done"}, 32'(done), 32'd1);
      checkValue({e.name, "_stall"}, 32'(stall), 32'(e.expStall));
      checkValue({e.name, "_addr"}, a0, e.expAddr);
      checkValue({e.name, "_we"}, 32'(we0), 32'(e.wr));
      checkValue({e.name, "_stable"}, 32'(stable), 32'd1);
      checkValue({e.name, "_misalign"}, 32'(misSeen), 32'd0);
      checkValue({e.name, "_buserr"}, 32'(errSeen), 32'd0);
      if (e.wr) begin
         checkValue({e.name, "_wstrb"}, 32'(s0), 32'(e.expStrb));
         checkValue({e.name, "_wdata"}, d0, e.expWdata);
      end else begin
         checkValue({e.name, "_rdata"}, rdata, e.expRead);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      int          stall = 0;
      int          reqn = 0;
      logic        seen = 1'b0;
      logic        stable = 1'b1;
      logic        misSeen = 1'b0;
      logic        errSeen = 1'b0;
      logic        done = 1'b0;
      logic [31:0] a0 = 32'h0;
      logic [31:0] d0 = 32'h0;
      logic [3:0]  s0 = 4'h0;
      logic        we0 = 1'b0;
      expQ.push_back(v);
      @(negedge clk);
      MemReadM   = v.rd;
      MemWriteM  = v.wr;
      funct3M    = v.f3;
      ALUResultM = v.addr;
      WriteDataM = v.wdata;
      bus_ready  = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         #1;
         misSeen = misSeen | MisalignM;
         errSeen = errSeen | BusErrM;
         if (seen && !bus_req) begin
            done = 1'b1;
         end else begin
            if (StallMem) stall++;
            if (bus_req) begin
               if (!seen) begin
                  a0 = bus_addr; s0 = bus_wstrb; d0 = bus_wdata; we0 = bus_we;
               end else if (bus_addr !== a0 || bus_wstrb !== s0 || bus_wdata !== d0 || bus_we !== we0) begin
                  stable = 1'b0;
               end
               seen = 1'b1;
               reqn++;
               bus_ready = (reqn == v.readyAt);
               bus_rdata = bus_ready ? v.rdata : 32'hDEAD_BEEF;
            end
            @(negedge clk);
            bus_ready = 1'b0;
         end
      end
      checkOutput(done, stall, a0, s0, d0, we0, stable, misSeen, errSeen, ReadDataM);
      MemReadM  = 1'b0;
      MemWriteM = 1'b0;
   endtask

   task automatic dut2Load(input string name, input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      rd2 = 1'b1; funct3M = 3'b010; ALUResultM = addr; ready2 = 1'b0;
      #1;
      checkValue({name, "_stall"}, 32'(StallMem2), 32'd1);
      @(negedge clk);
      ready2 = 1'b1; bus_rdata = data;
      #1;
      checkValue({name, "_req"}, 32'(bus_req2), 32'd1);
      checkValue({name, "_addr"}, bus_addr2, {addr[31:2], 2'b00});
      checkValue({name, "_we"}, 32'(bus_we2), 32'd0);
      checkValue({name, "_wstrb"}, 32'(bus_wstrb2), 32'd0);
      checkValue({name, "_wdata"}, bus_wdata2, 32'd0);
      @(negedge clk);
      ready2 = 1'b0; rd2 = 1'b0;
      #1;
      checkValue({name, "_data"}, ReadDataM2, data);
      checkValue({name, "_req_low"}, 32'(bus_req2), 32'd0);
      checkValue({name, "_misalign"}, 32'(MisalignM2), 32'd0);
   endtask

   initial begin
      vec_t vecs[$];
      int   reqc;
      int   errc;
      int   errCyc;
      logic [31:0] rdAtErr;

      vecs.push_back('{"sb_lane3",  1'b0, 1'b1, 3'b000, 32'h103, 32'h1234_56AB, 32'h0, 1,
                       32'h100, 4'b1000, 32'hABAB_ABAB, 32'h0, 2});
      vecs.push_back('{"sb_rdwr",   1'b1, 1'b1, 3'b000, 32'h000, 32'h0000_0055, 32'h0, 2,
                       32'h000, 4'b0001, 32'h5555_5555, 32'h0, 3});
      vecs.push_back('{"sh_hi",     1'b0, 1'b1, 3'b001, 32'h106, 32'hAAAA_BEEF, 32'h0, 2,
                       32'h104, 4'b1100, 32'hBEEF_BEEF, 32'h0, 3});
      vecs.push_back('{"sw",        1'b0, 1'b1, 3'b010, 32'h208, 32'h0123_4567, 32'h0, 3,
                       32'h208, 4'b1111, 32'h0123_4567, 32'h0, 4});
      vecs.push_back('{"lb_neg",    1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h0080_0000, 1,
                       32'h100, 4'h0, 32'h0, 32'hFFFF_FF80, 2});
      vecs.push_back('{"lbu",       1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h0080_0000, 1,
                       32'h100, 4'h0, 32'h0, 32'h0000_0080, 2});
      vecs.push_back('{"lhu_hi",    1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 1,
                       32'h100, 4'h0, 32'h0, 32'h0000_8001, 2});
      vecs.push_back('{"lw_wait5",  1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFE_F00D, 5,
                       32'h200, 4'h0, 32'h0, 32'hCAFE_F00D, 6});
      vecs.push_back('{"lh_neg",    1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h1234_8001, 1,
                       32'h100, 4'h0, 32'h0, 32'hFFFF_8001, 2});
      vecs.push_back('{"lb_lane1",  1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h0000_7F00, 1,
                       32'h100, 4'h0, 32'h0, 32'h0000_007F, 2});
      vecs.push_back('{"lb_lane3",  1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h8000_0000, 2,
                       32'h100, 4'h0, 32'h0, 32'hFFFF_FF80, 3});
      vecs.push_back('{"ld_badf3",  1'b1, 1'b0, 3'b011, 32'h300, 32'h0, 32'hFFFF_FFFF, 1,
                       32'h300, 4'h0, 32'h0, 32'h0000_0000, 2});
      vecs.push_back('{"lhu_lo",    1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'hFFFF_1234, 1,
                       32'h100, 4'h0, 32'h0, 32'h0000_1234, 2});

      rst = 1'b1;
      MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'b000;
      ALUResultM = 32'h0; WriteDataM = 32'h0;
      bus_rdata = 32'h0; bus_ready = 1'b0;
      rd2 = 1'b0; wr2 = 1'b0; ready2 = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkValue("reset_bus_req", 32'(bus_req), 32'd0);
      checkValue("reset_bus_we", 32'(bus_we), 32'd0);
      checkValue("reset_bus_addr", bus_addr, 32'd0);
      checkValue("reset_bus_wstrb", 32'(bus_wstrb), 32'd0);
      checkValue("reset_bus_wdata", bus_wdata, 32'd0);
      checkValue("reset_rdata", ReadDataM, 32'd0);
      checkValue("reset_stall", 32'(StallMem), 32'd0);
      checkValue("reset_misalign", 32'(MisalignM), 32'd0);
      checkValue("reset_buserr", 32'(BusErrM), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) applyStimulus(vecs[i]);

`ifdef DMEM_MISALIGN_TRAP_EN
      @(negedge clk);
      MemReadM = 1'b1; funct3M = 3'b001; ALUResultM = 32'h101;
      #1;
      checkValue("mis_no_stall", 32'(StallMem), 32'd0);
      @(negedge clk);
      MemReadM = 1'b0;
      #1;
      checkValue("mis_pulse", 32'(MisalignM), 32'd1);
      checkValue("mis_rdata_zero", ReadDataM, 32'd0);
      checkValue("mis_no_req", 32'(bus_req), 32'd0);
      @(negedge clk);
      #1;
      checkValue("mis_pulse_end", 32'(MisalignM), 32'd0);
      checkValue("mis_no_req_after", 32'(bus_req), 32'd0);
`else
      applyStimulus('{"lh_forced", 1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h0000_8765, 1,
                      32'h100, 4'h0, 32'h0, 32'hFFFF_8765, 2});
`endif

      @(negedge clk);
      MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h500;
      @(negedge clk);
      #1;
      checkValue("rst_pre_req", 32'(bus_req), 32'd1);
      rst = 1'b1;
      MemReadM = 1'b0;
      #1;
      checkValue("rst_async_req", 32'(bus_req), 32'd0);
      checkValue("rst_async_stall", 32'(StallMem), 32'd0);
      checkValue("rst_no_err", 32'(BusErrM), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      checkValue("rst_idle_req", 32'(bus_req), 32'd0);
      checkValue("rst_idle_err", 32'(BusErrM), 32'd0);
      applyStimulus('{"lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h504, 32'h0, 32'h1357_9BDF, 1,
                      32'h504, 4'h0, 32'h0, 32'h1357_9BDF, 2});

      dut2Load("to_prime", 32'h404, 32'h0BAD_F00D);
      @(negedge clk);
      rd2 = 1'b1; funct3M = 3'b010; ALUResultM = 32'h408; ready2 = 1'b0;
      reqc = 0; errc = 0; errCyc = -1; rdAtErr = 32'hFFFF_FFFF;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (bus_req2) reqc++;
         if (BusErrM2) begin
            errc++;
            errCyc = c;
            rdAtErr = ReadDataM2;
            rd2 = 1'b0;
         end
         @(negedge clk);
      end
      #1;
      checkValue("to_req_cycles", 32'(reqc), 32'd4);
      checkValue("to_err_pulses", 32'(errc), 32'd1);
      checkValue("to_err_cycle", 32'(errCyc), 32'd5);
      checkValue("to_rdata_zero", rdAtErr, 32'd0);
      checkValue("to_idle_stall", 32'(StallMem2), 32'd0);
      dut2Load("to_recover", 32'h40C, 32'h2468_ACE0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller between the pipeline's Memory stage and a handshaked data bus. Accepts one load or store per instruction from the M stage, issues it as a word-aligned bus transaction with byte strobes, holds the pipeline via a stall request until the bus completes, and returns load data already lane-selected and sign/zero-extended. Unresponsive transactions are bounded by a timeout counter.

## Interface
- TIMEOUT_CYCLES, 255: maximum REQ cycles without bus_ready before abort (1..255).

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- MemReadM  in  1  M-stage instruction is a load
- MemWriteM  in  1  M-stage instruction is a store
- funct3M  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- ALUResultM  in  32  byte address
- WriteDataM  in  32  unaligned store data (rs2 value)
- ReadDataM  out  32  extended load result, valid in DONE
- StallMem  out  1  stall request to hazard unit (freezes F/D/E/M, bubbles W)
- MisalignM  out  1  one-cycle pulse: misaligned access detected
- BusErrM  out  1  one-cycle pulse: transaction timed out
- bus_req  out  1  request valid
- bus_we  out  1  1 = write
- bus_addr  out  32  {ALUResultM[31:2], 2'b00}
- bus_wstrb  out  4  byte-lane write enables
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data, valid with bus_ready
- bus_ready  in  1  transaction complete

## Operation
- States: IDLE, REQ, DONE.
- access = MemReadM | MemWriteM. MemReadM & MemWriteM together is illegal; store wins.
- IDLE: if access & ~misaligned: register addr, we, strobe, wdata, funct3, lane; go REQ. Otherwise stay.
- REQ: bus_req=1 with registered fields stable. If bus_ready: capture bus_rdata into buffer, go DONE. If timeout counter reaches TIMEOUT_CYCLES: pulse BusErrM, buffer = 0, go DONE.
- DONE: bus_req=0, StallMem=0, ReadDataM from buffer; M-stage instruction advances; go IDLE unconditionally (no back-to-back re-trigger of the same instruction).
- StallMem = (IDLE & access & ~misaligned) | REQ (combinational).
- Store strobes: sb 4'b0001<<addr[1:0]; sh 4'b0011<<{addr[1],1'b0}; sw 4'hF. wdata: sb {4{d[7:0]}}, sh {2{d[15:0]}}, sw d.
- Load: byte = rdata >> (8*addr[1:0]); half = rdata >> (16*addr[1]); lb/lh sign-extend, lbu/lhu zero-extend, lw pass. Other funct3: ReadDataM = 0.
- Misaligned: sh/lh/lhu with addr[0]=1; sw/lw with addr[1:0]!=0.
- ReadDataM outside DONE: holds last buffer value.

## Timing
- Reset values: state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_wstrb 0, bus_wdata 0, ReadDataM 0, StallMem 0, MisalignM 0, BusErrM 0, timeout counter 0.
- Reset mid-transaction: bus_req drops asynchronously; no completion, no error pulse.
- Latency with bus_ready in first REQ cycle: 2 stall cycles (IDLE-detect, REQ), data in the 3rd cycle (DONE).
- Each extra wait cycle adds one stall cycle. Counter clears on entering REQ, increments per REQ cycle without ready.
- bus_ready sampled only in REQ; ignored elsewhere. bus_ready in the same cycle as timeout expiry: completion wins, no BusErrM.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: misaligned access issues no bus transaction, no stall, MisalignM pulses for one cycle, loads return 0.
- Undefined: misaligned check disabled, MisalignM tied 0; offending low address bits are forced to the natural alignment (addr[0] cleared for half, addr[1:0] cleared for word) and the access proceeds normally.

## Test plan
- sb 0x1234_56AB to 0x103, bus_ready after 1 cycle -> bus_addr 0x100, wstrb 4'b1000, wdata 0xABABABAB, StallMem high 2 cycles.
- lb 0x102, bus_rdata 0x0080_0000 -> ReadDataM 0xFFFFFF80; lbu same -> 0x00000080; lhu 0x102, rdata 0x8001_0000 -> 0x00008001.
- lw 0x200, bus_ready delayed 5 cycles -> StallMem high 6 cycles, bus fields stable throughout, ReadDataM = rdata in DONE.
- TIMEOUT_CYCLES=4, bus_ready never -> BusErrM one pulse after 4 REQ cycles, ReadDataM 0, return IDLE.
- lh at 0x101 with DMEM_MISALIGN_TRAP_EN -> MisalignM pulse, bus_req never high; without macro -> access at lane 0, no pulse.
- rst asserted in REQ -> bus_req 0 immediately, state IDLE after release, next load completes normally.
